// File: rtl/cpu_pkg.sv
// Shared CID2 core definitions: PC controller states and default sizing.
// Used by pc_jump_ctrl and pc_next_sel.
package cpu_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} pc_state_t;

  localparam int PC_W_DEF     = 8;
  localparam int RESET_PC_DEF = 0;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection and taken decision for the execute cycle.
// Optional jump-if-not-zero decode is enabled by defining JMPNZ_EN.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] target_i,
  input  logic            halt_i,
  input  logic            jmp_i,
  input  logic            jmpz_i,
`ifdef JMPNZ_EN
  input  logic            jmpnz_i,
`endif
  input  logic            zero_flag_i,
  output logic [PC_W-1:0] next_pc,
  output logic            taken
);

  logic branch_hit;

  always_comb begin
    branch_hit = jmp_i || (jmpz_i && zero_flag_i);
`ifdef JMPNZ_EN
    branch_hit = branch_hit || (jmpnz_i && !zero_flag_i);
`endif
    next_pc = pc + PC_W'(1);
    taken   = 1'b0;
    // halt wins over every branch and never reports a taken jump
    if (halt_i) begin
      next_pc = PC_W'(RESET_PC);
    end else if (branch_hit) begin
      next_pc = target_i;
      taken   = 1'b1;
    end
  end

endmodule

// File: rtl/pc_jump_ctrl.sv
// CID2 program counter / jump controller: IDLE -> FETCH (req/ack) -> EXEC loop.
// Define JMPNZ_EN to add the jmpnz_i jump-if-not-zero decode input.
module pc_jump_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start_i,
  output logic            fetch_req_o,
  output logic [PC_W-1:0] fetch_addr_o,
  input  logic            fetch_ack_i,
  input  logic            jmp_i,
  input  logic            jmpz_i,
`ifdef JMPNZ_EN
  input  logic            jmpnz_i,
`endif
  input  logic            halt_i,
  input  logic [PC_W-1:0] target_i,
  input  logic            zero_flag_i,
  output logic [PC_W-1:0] pc_o,
  output logic            taken_o,
  output logic            busy_o
);

  pc_state_t       state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] next_pc;
  logic            taken_nxt;

  pc_next_sel #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_next_sel (
    .pc          (pc),
    .target_i    (target_i),
    .halt_i      (halt_i),
    .jmp_i       (jmp_i),
    .jmpz_i      (jmpz_i),
`ifdef JMPNZ_EN
    .jmpnz_i     (jmpnz_i),
`endif
    .zero_flag_i (zero_flag_i),
    .next_pc     (next_pc),
    .taken       (taken_nxt)
  );

  // Outputs are registered alongside the state so they change only on edges
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= PC_W'(RESET_PC);
      fetch_req_o <= 1'b0;
      taken_o     <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      taken_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state       <= FETCH;
            fetch_req_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        FETCH: begin
          if (fetch_ack_i) begin
            state       <= EXEC;
            fetch_req_o <= 1'b0;
          end
        end
        EXEC: begin
          pc      <= next_pc;
          taken_o <= taken_nxt;
          if (halt_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            state       <= FETCH;
            fetch_req_o <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          fetch_req_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o         = pc;
  assign fetch_addr_o = pc;

endmodule
